register_sync: RTL and testbench
================================

REGISTER_SYNC -- requirements
Module: register_sync

Interface
REQ-001 Parameter reg_width, default 1: bus width in bits, minimum 1.
REQ-002 Parameter reg_preset, default all-zero (reg_width bits): reset value of every internal stage and of reg_o.
REQ-003 Parameter sync_stages, default 2: number of synchronizer flops, minimum 2; values below 2 SHALL fail elaboration.
REQ-004 Parameter stable_cnt, default 0: enabled cycles the synchronized word must hold before reg_o updates; 0 = bypass; maximum 255.
REQ-005 clk  input  1  destination-domain clock; all flops rise-edge triggered.
REQ-006 nrst  input  1  reset, asynchronous, active-low; one clock, async active-low reset, fixed.
REQ-007 clk_en  input  1  enable; stages, filter and outputs advance only on edges where clk_en=1.
REQ-008 reg_i  input  reg_width  word from a foreign clock domain, asynchronous to clk.
REQ-009 reg_o  output  reg_width  synchronized (and optionally stability-filtered) copy of reg_i, registered.
REQ-010 reg_changed  output  1  one-cycle pulse on the clk edge at which reg_o takes a value different from its previous value.

Function
REQ-011 Stage chain: on each enabled edge, stage[0] <= reg_i and stage[k] <= stage[k-1] for k = 1..sync_stages-1.
REQ-012 Bypass (stable_cnt=0): reg_o SHALL be stage[sync_stages-1] directly; latency from a reg_i change to reg_o = sync_stages enabled edges (2 by default).
REQ-013 Filter (stable_cnt>0): a candidate register and an 8-bit counter; on each enabled edge, if stage[last] != candidate then candidate <= stage[last] and counter <= 0; otherwise counter increments, saturating at stable_cnt.
REQ-014 Filter: reg_o <= candidate on the enabled edge at which the counter equals stable_cnt; total latency = sync_stages + stable_cnt + 1 enabled edges for a held input.
REQ-015 A change of the synchronized word while the counter is counting SHALL restart the count; reg_o SHALL never show a word that was not stable for stable_cnt consecutive enabled cycles.
REQ-016 clk_en=0 SHALL freeze all stages, candidate, counter and reg_o; reg_changed SHALL be 0 on such edges.
REQ-017 reg_changed SHALL be computed by comparing the next and current reg_o values and registered, so it is high exactly during the cycle after reg_o updates to a new value.
REQ-018 Bits are synchronized independently; no cross-bit coherency is guaranteed in bypass mode. Callers needing coherency use stable_cnt>0 or slow-changing data.
REQ-019 No combinational path from reg_i to any output.

Reset
REQ-020 nrst=0 SHALL immediately set every stage, the candidate and reg_o to reg_preset, set the counter to 0 and set reg_changed to 0, independent of clk and clk_en.
REQ-021 Release of nrst takes effect on the next enabled edge; reset asserted mid-filter discards the pending count.
REQ-022 Callers with no reset tie nrst=1; flop power-up values SHALL equal reg_preset via initial values.

Structure
REQ-023 Single flat module; no sub-modules. The stage chain is a generated array of width reg_width × sync_stages.
REQ-024 No shared package; all constants are module parameters. Synchronizer flops carry the toolchain's synchronizer attribute.

Verification
REQ-025 Reset: nrst=0 with reg_preset=16'hA5A5 -> reg_o=16'hA5A5 and reg_changed=0 without a clock edge.
REQ-026 Bypass latency: width 16, reg_i 0->16'h1234 held, clk_en=1 -> reg_o=16'h1234 on the 2nd edge and reg_changed=1 the following cycle only.
REQ-027 Enable: clk_en=0 for 5 cycles after the reg_i change -> reg_o unchanged. Re-enable -> update after 2 enabled edges.
REQ-028 Filter: stable_cnt=3, reg_i toggles 8'h01/8'h02 every 2 cycles -> reg_o stays at reset value. Hold 8'h02 -> reg_o=8'h02 after 2+3+1 edges.
REQ-029 Reset mid-operation: nrst pulsed low while the count equals 2 -> reg_o=preset and the counter restarts from 0 after release.
REQ-030 Width 96, random reg_i held 10 cycles per value -> reg_o matches each held value sync_stages cycles later.

Source files
------------

// File: rtl/register_sync.sv
// Multi-flop synchronizer for a word arriving from a foreign clock domain,
// with an optional filter that only forwards words held for stable_cnt cycles.
module register_sync #(
  parameter int unsigned          reg_width   = 1,
  parameter logic [reg_width-1:0] reg_preset  = '0,
  parameter int unsigned          sync_stages = 2,
  parameter int unsigned          stable_cnt  = 0
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 clk_en,
  input  logic [reg_width-1:0] reg_i,
  output logic [reg_width-1:0] reg_o,
  output logic                 reg_changed
);

  if (reg_width < 1) begin : g_bad_width
    $error("register_sync: reg_width must be at least 1");
  end
  if (sync_stages < 2) begin : g_bad_stages
    $error("register_sync: sync_stages must be at least 2");
  end
  if (stable_cnt > 255) begin : g_bad_stable
    $error("register_sync: stable_cnt must not exceed 255");
  end

  localparam logic [7:0] stable_max = 8'(stable_cnt);

  (* ASYNC_REG = "TRUE" *) logic [reg_width-1:0] stage_q [sync_stages];

  logic [reg_width-1:0] sync_w;
  logic [reg_width-1:0] next_w;
  logic                 changed_q;

  assign sync_w = stage_q[sync_stages-1];

  // NOTE: the synchronizer chain is a handful of flops, not a RAM, so every
  // stage is reset to the preset; that keeps reg_o defined right after reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < sync_stages; k++) stage_q[k] <= reg_preset;
    end else if (clk_en) begin
      // NOTE: non-blocking assignments make every stage read its neighbour's
      // old value, so the loop order does not matter.
      stage_q[0] <= reg_i;
      for (int k = 1; k < sync_stages; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  if (stable_cnt == 0) begin : g_bypass
    assign reg_o  = sync_w;
    assign next_w = clk_en ? stage_q[sync_stages-2] : sync_w;
  end else begin : g_filter
    logic [reg_width-1:0] cand_q, cand_d;
    logic [reg_width-1:0] out_q, out_d;
    logic [7:0]           cnt_q, cnt_d;

    // Any change of the synchronized word restarts the count; the output only
    // loads the candidate on the edge where the count reaches stable_cnt.
    always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      out_d  = out_q;
      if (clk_en) begin
        if (sync_w != cand_q) begin
          cand_d = sync_w;
          cnt_d  = '0;
        end else begin
          if (cnt_q != stable_max) cnt_d = cnt_q + 8'd1;
          if (cnt_d == stable_max) out_d = cand_q;
        end
      end
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        cand_q <= reg_preset;
        cnt_q  <= '0;
        out_q  <= reg_preset;
      end else begin
        cand_q <= cand_d;
        cnt_q  <= cnt_d;
        out_q  <= out_d;
      end
    end

    assign reg_o  = out_q;
    assign next_w = out_d;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) changed_q <= 1'b0;
    else       changed_q <= clk_en && (next_w != reg_o);
  end

  assign reg_changed = changed_q;

endmodule

// File: tb/tb_register_sync.sv
// Bench for register_sync: three instances (bypass, filtered, wide) driven by
// directed and random stimulus and compared against a queue-based model.
module tb_register_sync;

  localparam int unsigned wid_n [3] = '{16, 8, 96};
  localparam int unsigned stg_n [3] = '{2, 2, 3};
  localparam int unsigned stb_n [3] = '{0, 3, 0};
  localparam logic [95:0] pre_n [3] = '{96'hA5A5, 96'h0, 96'h0};

  logic        clk = 1'b0;
  logic        nrst [3];
  logic        en   [3];
  logic [95:0] din  [3];
  logic [15:0] q0;
  logic [7:0]  q1;
  logic [95:0] q2;
  logic        chg0, chg1, chg2;

  int total = 0;
  int bad   = 0;

  logic [95:0] pipe [3][$];
  logic [95:0] hist [3][$];
  logic [95:0] m_o  [3];
  logic        m_chg[3];

  always #5 clk = ~clk;

  register_sync #(.reg_width(16), .reg_preset(16'hA5A5), .sync_stages(2), .stable_cnt(0)) u_byp (
    .clk(clk), .nrst(nrst[0]), .clk_en(en[0]), .reg_i(din[0][15:0]), .reg_o(q0), .reg_changed(chg0));
  register_sync #(.reg_width(8), .reg_preset(8'h00), .sync_stages(2), .stable_cnt(3)) u_flt (
    .clk(clk), .nrst(nrst[1]), .clk_en(en[1]), .reg_i(din[1][7:0]), .reg_o(q1), .reg_changed(chg1));
  register_sync #(.reg_width(96), .reg_preset(96'h0), .sync_stages(3), .stable_cnt(0)) u_wide (
    .clk(clk), .nrst(nrst[2]), .clk_en(en[2]), .reg_i(din[2]), .reg_o(q2), .reg_changed(chg2));

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] wmask(input int id);
    if (wid_n[id] >= 96) return '1;
    return (96'd1 << wid_n[id]) - 96'd1;
  endfunction

  function automatic logic [95:0] dut_o(input int id);
    case (id)
      0:       return 96'(q0);
      1:       return 96'(q1);
      default: return q2;
    endcase
  endfunction

  function automatic logic dut_chg(input int id);
    case (id)
      0:       return chg0;
      1:       return chg1;
      default: return chg2;
    endcase
  endfunction

  // Model: a delay line of sync_stages samples; with filtering, the output
  // takes a word once the last stable_cnt+1 synchronized samples all agree.
  task automatic model_reset(input int id);
    pipe[id].delete();
    for (int k = 0; k < int'(stg_n[id]); k++) pipe[id].push_back(pre_n[id]);
    hist[id].delete();
    hist[id].push_back(pre_n[id]);
    m_o[id]   = pre_n[id];
    m_chg[id] = 1'b0;
  endtask

  task automatic model_edge(input int id, input logic ena, input logic [95:0] d);
    logic [95:0] s_prev, nxt;
    bit          steady;
    if (!ena) begin
      m_chg[id] = 1'b0;
      return;
    end
    s_prev = pipe[id][0];
    void'(pipe[id].pop_front());
    pipe[id].push_back(d);
    if (stb_n[id] == 0) begin
      nxt = pipe[id][0];
    end else begin
      nxt = m_o[id];
      hist[id].push_back(s_prev);
      if (hist[id].size() > int'(stb_n[id]) + 1) void'(hist[id].pop_front());
      if (hist[id].size() == int'(stb_n[id]) + 1) begin
        steady = 1'b1;
        foreach (hist[id][j]) if (hist[id][j] != hist[id][0]) steady = 1'b0;
        if (steady) nxt = hist[id][0];
      end
    end
    m_chg[id] = (nxt != m_o[id]);
    m_o[id]   = nxt;
  endtask

  always @(posedge clk) begin
    for (int id = 0; id < 3; id++)
      if (nrst[id]) model_edge(id, en[id], din[id] & wmask(id));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int id = 0; id < 3; id++) begin
        check($sformatf("model_o%0d", id), dut_o(id), m_o[id]);
        check($sformatf("model_chg%0d", id), 96'(dut_chg(id)), 96'(m_chg[id]));
      end
    end
  endtask

  initial begin
    logic [95:0] val;
    for (int id = 0; id < 3; id++) begin
      nrst[id] = 1'b1;
      en[id]   = 1'b1;
      din[id]  = '0;
    end
    #1;
    for (int id = 0; id < 3; id++) begin
      nrst[id] = 1'b0;
      model_reset(id);
    end
    #1;
    check("reset_o_preset", 96'(q0), 96'hA5A5);
    check("reset_chg", 96'(chg0), 96'h0);
    check("reset_o_filter", 96'(q1), 96'h0);

    @(negedge clk);
    for (int id = 0; id < 3; id++) nrst[id] = 1'b1;
    step(4);
    check("byp_settle_zero", 96'(q0), 96'h0);

    din[0] = 96'h1234;
    step(1);
    check("byp_edge1_old", 96'(q0), 96'h0);
    step(1);
    check("byp_edge2_new", 96'(q0), 96'h1234);
    check("byp_edge2_chg", 96'(chg0), 96'h1);
    step(1);
    check("byp_chg_one_cycle", 96'(chg0), 96'h0);

    din[0] = 96'h5678;
    en[0]  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("en_frozen_o", 96'(q0), 96'h1234);
      check("en_frozen_chg", 96'(chg0), 96'h0);
    end
    en[0] = 1'b1;
    step(1);
    check("en_resume_edge1", 96'(q0), 96'h1234);
    step(1);
    check("en_resume_edge2", 96'(q0), 96'h5678);

    for (int i = 0; i < 8; i++) begin
      din[1] = (i % 2 == 0) ? 96'h02 : 96'h01;
      step(2);
      check("flt_toggle_hold_reset", 96'(q1), 96'h0);
    end
    din[1] = 96'h02;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("flt_hold_pending", 96'(q1), 96'h0);
    end
    step(1);
    check("flt_hold_out", 96'(q1), 96'h02);
    check("flt_hold_chg", 96'(chg1), 96'h1);

    din[1] = 96'h07;
    step(5);
    nrst[1] = 1'b0;
    model_reset(1);
    #1;
    check("mid_rst_o", 96'(q1), 96'h0);
    check("mid_rst_chg", 96'(chg1), 96'h0);
    step(1);
    nrst[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("post_rst_pending", 96'(q1), 96'h0);
    end
    step(1);
    check("post_rst_out", 96'(q1), 96'h07);

    for (int v = 0; v < 20; v++) begin
      val    = {$urandom, $urandom, $urandom};
      din[2] = val;
      step(3);
      check("wide_latency", q2, val);
      step(7);
    end

    for (int i = 0; i < 400; i++) begin
      din[0] = 96'($urandom_range(0, 65535));
      en[0]  = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 3) == 0) din[1] = 96'($urandom_range(1, 3));
      en[1]  = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 4) == 0) din[2] = {$urandom, $urandom, $urandom};
      en[2]  = ($urandom_range(0, 9) < 9);
      if ($urandom_range(0, 49) == 0) begin
        nrst[1] = 1'b0;
        model_reset(1);
        step(1);
        nrst[1] = 1'b1;
      end else begin
        step(1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
